// File: rtl/p_hardisc.sv
// Shared types and constants for the register-file scrubber.
// Imported by the scrub controller and its pointer sub-block.
package p_hardisc;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_CHECK,
    ST_REPAIR
  } scrub_state;

  localparam logic [4:0] SCRUB_ADD_FIRST = 5'd1;
  localparam logic [4:0] SCRUB_ADD_LAST  = 5'd31;

  // Hard-control CSR layout
  localparam int unsigned CSR_HC_EN_BIT  = 0;
  localparam int unsigned CSR_HC_LVL_LSB = 1;
  localparam int unsigned CSR_HC_LVL_W   = 2;

  // Advance a register address by 0..2 inside x1..x31
  function automatic logic [4:0] add_wrap(
    input logic [4:0] a,
    input logic [1:0] n
  );
    logic [5:0] s;
    s = {1'b0, a} + {4'b0000, n};
    if (s > {1'b0, SCRUB_ADD_LAST}) begin
      s = s - {1'b0, SCRUB_ADD_LAST};
    end
    return s[4:0];
  endfunction

endpackage

// File: rtl/scrub_ptr.sv
// Scrub address pointer over x1..x31.
// Advances by the number of read ports granted this cycle.
module scrub_ptr
  import p_hardisc::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] adv_i,
  output logic [4:0] ptr_o,
  output logic [4:0] nxt_o
);

  logic [4:0] ptr_q;
  logic [4:0] ptr_d;

  // Next pointer and the address one step ahead
  always_comb begin
    ptr_d = add_wrap(ptr_q, adv_i);
    nxt_o = add_wrap(ptr_q, 2'd1);
    ptr_o = ptr_q;
  end

  // Pointer register, restarts at x1
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= SCRUB_ADD_FIRST;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rf_scrub_ctrl.sv
// Background register-file scrubber: steals free read ports,
// checks results a cycle later and issues repair writes.
module rf_scrub_ctrl
  import p_hardisc::*;
#(
  parameter int unsigned STARVE_LIM = 15,
  parameter int unsigned ERRCNT_W   = 8
) (
  input  logic                s_clk_i,
  input  logic                s_reset_i,
  input  logic                s_enable_i,
  input  logic                s_restart_en_i,
  input  logic [1:0]          s_free_rp_i,
  input  logic                s_stall_i,
  input  logic [1:0]          s_rp_err_i,
  output logic [1:0]          s_scrub_gnt_o,
  output logic [4:0]          s_scrub_add0_o,
  output logic [4:0]          s_scrub_add1_o,
  output logic                s_repair_req_o,
  output logic [4:0]          s_repair_add_o,
  input  logic                s_repair_ack_i,
  output logic                s_restart_o,
  output logic [ERRCNT_W-1:0] s_errcnt_o,
  output logic                s_busy_o
);

  localparam logic [7:0] LIM = 8'(STARVE_LIM);

  scrub_state state_q, state_d;

  logic [1:0]          rgnt_q, rgnt_d;
  logic [4:0]          radd0_q, radd0_d;
  logic [4:0]          radd1_q, radd1_d;
  logic [1:0]          pend_q, pend_d;
  logic [4:0]          padd0_q, padd0_d;
  logic [4:0]          padd1_q, padd1_d;
  logic [7:0]          starve_q, starve_d;
  logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;

  logic       in_scan, in_check, in_rep;
  logic [1:0] err_v;
  logic       err_any;
  logic [1:0] gnt;
  logic       gnt_any;
  logic [1:0] adv;
  logic [4:0] ptr, nxt;
  logic [4:0] add0, add1;
  logic       ack_ok;
  logic [1:0] pend_clr;
  logic       pend_last;
  logic       starve_inc;
  logic       restart;

  // Stall does not gate anything: a stalled OP stage without free
  // ports starves the scrubber exactly like a running one.
  logic unused_stall;
  assign unused_stall = s_stall_i;

  // Grant and handshake qualifiers
  always_comb begin
    in_scan   = (state_q == ST_SCAN);
    in_check  = (state_q == ST_CHECK);
    in_rep    = (state_q == ST_REPAIR);
    err_v     = s_rp_err_i & rgnt_q & {2{in_check}};
    err_any   = |err_v;
    gnt       = (s_enable_i & (in_scan | (in_check & ~err_any)))
              ? s_free_rp_i : 2'b00;
    gnt_any   = |gnt;
    adv       = {1'b0, gnt[0]} + {1'b0, gnt[1]};
    add0      = gnt[0] ? ptr : 5'd0;
    add1      = gnt[1] ? (gnt[0] ? nxt : ptr) : 5'd0;
    ack_ok    = in_rep & s_repair_ack_i;
    pend_clr  = pend_q & (pend_q - 2'd1);
    pend_last = ack_ok & (pend_clr == 2'b00);
  end

  scrub_ptr u_ptr (
    .clk_i (s_clk_i),
    .rst_i (s_reset_i),
    .adv_i (adv),
    .ptr_o (ptr),
    .nxt_o (nxt)
  );

  // FSM state register
  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (s_enable_i) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (!s_enable_i)  state_d = ST_IDLE;
        else if (gnt_any) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (err_any)          state_d = ST_REPAIR;
        else if (gnt_any)     state_d = ST_CHECK;
        else if (!s_enable_i) state_d = ST_IDLE;
        else                  state_d = ST_SCAN;
      end
      ST_REPAIR: begin
        if (pend_last) begin
          state_d = s_enable_i ? ST_SCAN : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    s_scrub_gnt_o  = gnt;
    s_scrub_add0_o = add0;
    s_scrub_add1_o = add1;
    s_repair_req_o = in_rep;
    s_repair_add_o = 5'd0;
    if (in_rep) begin
      s_repair_add_o = pend_q[0] ? padd0_q : padd1_q;
    end
    s_restart_o = restart;
    s_errcnt_o  = errcnt_q;
    s_busy_o    = (state_q != ST_IDLE);
  end

  // Read tracking, repair queue and counters
  always_comb begin
    rgnt_d   = rgnt_q;
    radd0_d  = radd0_q;
    radd1_d  = radd1_q;
    pend_d   = pend_q;
    padd0_d  = padd0_q;
    padd1_d  = padd1_q;
    starve_d = starve_q;
    errcnt_d = errcnt_q;

    if (gnt_any) begin
      rgnt_d  = gnt;
      radd0_d = add0;
      radd1_d = add1;
    end

    if (err_any) begin
      pend_d  = err_v;
      padd0_d = radd0_q;
      padd1_d = radd1_q;
    end else if (ack_ok) begin
      pend_d = pend_clr;
    end

    if (ack_ok && (errcnt_q != {ERRCNT_W{1'b1}})) begin
      errcnt_d = errcnt_q + ERRCNT_W'(1);
    end

    starve_inc = (in_scan | in_check) & (s_free_rp_i == 2'b00);
    restart    = starve_inc & s_restart_en_i
               & (starve_q >= (LIM - 8'd1));

    if (state_q == ST_IDLE) begin
      starve_d = 8'd0;
    end else if (gnt_any || restart) begin
      starve_d = 8'd0;
    end else if (starve_inc && (starve_q < LIM)) begin
      starve_d = starve_q + 8'd1;
    end
  end

  // Datapath registers
  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      rgnt_q   <= 2'b00;
      radd0_q  <= 5'd0;
      radd1_q  <= 5'd0;
      pend_q   <= 2'b00;
      padd0_q  <= 5'd0;
      padd1_q  <= 5'd0;
      starve_q <= 8'd0;
      errcnt_q <= '0;
    end else begin
      rgnt_q   <= rgnt_d;
      radd0_q  <= radd0_d;
      radd1_q  <= radd1_d;
      pend_q   <= pend_d;
      padd0_q  <= padd0_d;
      padd1_q  <= padd1_d;
      starve_q <= starve_d;
      errcnt_q <= errcnt_d;
    end
  end

endmodule

// File: doc/rf_scrub_ctrl.md
Name: rf_scrub_ctrl

Overview:
Background scrub controller for the register-file read ports. It claims read ports left free by the instruction in the OP stage and walks addresses x1..x31. It collects mismatch results one cycle after each read and issues repair writes over a req/ack handshake. It sits beside the ID/OP boundary, is configured by the hard-control CSR, and requests a pipeline restart when the pipeline starves it of read ports.

Parameters:
STARVE_LIM, 15, consecutive no-free-port cycles in SCAN before a restart request (1..255)
ERRCNT_W, 8, width of the saturating repaired-error counter

Ports:
s_clk_i  in  1  clock
s_reset_i  in  1  synchronous reset, active-high
s_enable_i  in  1  scrubbing enabled (CSR level >= 2)
s_restart_en_i  in  1  restart insertion enabled (CSR level == 3)
s_free_rp_i  in  2  bit k = read port k unused by OP-stage instruction this cycle
s_stall_i  in  1  OP stage stalled; the grant is still valid
s_rp_err_i  in  2  bit k = mismatch on port k for the read granted in the previous cycle
s_scrub_gnt_o  out  2  bit k = scrubber drives read port k this cycle
s_scrub_add0_o  out  5  address on port 0 when granted
s_scrub_add1_o  out  5  address on port 1 when granted
s_repair_req_o  out  1  repair write request
s_repair_add_o  out  5  register to repair, stable while req high
s_repair_ack_i  in  1  repair done; accepted only while req high
s_restart_o  out  1  one-cycle pipeline restart request
s_errcnt_o  out  ERRCNT_W  saturating count of completed repairs
s_busy_o  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, scan pointer = 1, starve counter = 0, s_errcnt_o = 0, all other outputs 0. Reset takes priority over every event, including an in-flight repair; any pending request is dropped.
- States:
  - IDLE: leave for SCAN when s_enable_i = 1.
  - SCAN: issue reads.
  - CHECK: results of the previous read arrive.
  - REPAIR: handshake in progress.
- Grants are combinational and asserted only in SCAN and CHECK: s_scrub_gnt_o = s_free_rp_i.
- Port 0 reads the pointer p. Port 1 reads p when port 0 is not free. Port 1 reads nxt(p) when both ports are free.
- nxt(a) = a+1, except nxt(31) = 1. x0 is never scrubbed.
- Pointer advances by the number of granted ports: +1 or +2 with wrap. From 30, +2 gives 1; from 31, +2 gives 2.
- Any grant moves the FSM to CHECK, where the addresses of the granted ports are registered.
- In CHECK, s_rp_err_i is sampled against the registered grants; bits without a grant are ignored.
  - No error: go back to SCAN. A grant issued in the same CHECK cycle is pipelined and stays in CHECK.
  - Any error: go to REPAIR. A new grant issued in that same cycle is suppressed, so gnt is forced to 0 and the pointer does not advance.
- REPAIR:
  - s_repair_req_o = 1 with the address of the lowest erroneous port.
  - On ack, s_errcnt_o increments, saturating at all-ones.
  - If a second erroneous port is pending, it is served next with no idle cycle: the new address appears in the cycle after the ack.
  - After the last ack: go to SCAN if enabled, else IDLE.
- Disable (s_enable_i = 0):
  - In SCAN or CHECK: go to IDLE after the CHECK results are consumed. Any error found still leads to REPAIR.
  - In REPAIR: finish all pending repairs, then IDLE.
  - The pointer is retained across disable.
- Starvation:
  - The counter increments in each SCAN/CHECK cycle with s_free_rp_i = 0 and clears on any grant.
  - When it reaches STARVE_LIM with s_restart_en_i = 1, s_restart_o pulses for one cycle and the counter clears.
  - With s_restart_en_i = 0 the counter saturates at STARVE_LIM and no restart is issued.
  - The counter holds in REPAIR and clears in IDLE.
- s_stall_i has no effect on grants. It only qualifies the starve count: a stalled cycle with no free port still counts.
- Latency: read grant at cycle t, result at t+1, req at t+2 at the earliest.

Decomposition:
- Shared package p_hardisc:
  - typedef scrub_state (IDLE, SCAN, CHECK, REPAIR)
  - constants SCRUB_ADD_FIRST = 5'd1 and SCRUB_ADD_LAST = 5'd31
  - CSR bit positions for the enable and level fields
- Sub-module scrub_ptr: the pointer register with +0/+1/+2 wrap-around increment and the nxt() output.
- FSM, starve counter and error counter stay in the top module.

Test Plan:
1. Reset, enable, s_free_rp_i = 2'b01 every cycle, no errors -> port-0 addresses 1, 2, ..., 31, 1. Address 0 never appears. s_errcnt_o stays 0.
2. Pointer = 30, s_free_rp_i = 2'b11 -> add0 = 30, add1 = 31. Next grant has add0 = 1, add1 = 2.
3. Grant at addresses 7 and 8, s_rp_err_i = 2'b11 next cycle, ack delayed 3 cycles each -> req with add = 7 held 3 cycles, then add = 8. s_errcnt_o = 2. No grants during REPAIR.
4. s_restart_en_i = 1, s_free_rp_i = 0 for 15 cycles in SCAN -> s_restart_o pulses exactly in cycle 15. Repeat with s_restart_en_i = 0 -> no pulse.
5. Error at address 5, drop s_enable_i while req is high, then ack -> req deasserts, state goes to IDLE, pointer retained. Re-enable -> scan resumes at 6.
6. Assert s_reset_i during REPAIR -> next cycle req = 0, state IDLE, pointer = 1, s_errcnt_o = 0.
